// File: rtl/inst_rom_responder_pkg.sv
// Shared definitions for the instruction ROM responder slice.
//   ADDR_W / DATA_W     : fetch address and instruction widths
//   INIT_PC             : reset fetch address of the core
//   DEFAULT_BASE_ADDR   : byte address of word 0 of the instruction store
//   fetch_resp_t        : one pipeline stage of the response path
package inst_rom_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] INIT_PC           = 32'hBFC0_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = INIT_PC;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic              err;
    logic [DATA_W-1:0] data;
  } fetch_resp_t;

endpackage

// File: rtl/inst_rom_array.sv
// Single-port instruction storage with synchronous read and write.
//   clk             : clock
//   rd_en           : read enable; when low rd_data holds its last value
//   rd_idx          : read word index
//   rd_data         : registered read data
//   wr_en           : write strobe
//   wr_idx, wr_data : write word index and data
// A read and write to the same index in one cycle returns the old word.
// Contents are not reset.
module inst_rom_array
  import inst_rom_responder_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/inst_rom_responder.sv
// Instruction-side SRAM responder: returns the addressed instruction
// LATENCY cycles after an accepted fetch, flags misaligned/out-of-range pcs.
//   clk, rst                  : clock, synchronous active-high reset
//   rom_en_i, pc_i            : fetch request valid and byte address
//   stall_i                   : freeze all in-flight state
//   flush_i                   : drop all in-flight and same-cycle requests
//   load_en_i/idx_i/data_i    : preload write port
//   inst_o, inst_valid_o      : response data and valid
//   inst_pc_o, err_o          : response pc and address error
module inst_rom_responder
  import inst_rom_responder_pkg::*;
#(
  parameter  int unsigned       DEPTH_WORDS = 1024,
  parameter  int unsigned       LATENCY     = 1,
  parameter  logic [ADDR_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  localparam int unsigned       IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              load_en_i,
  input  logic [IDX_W-1:0]  load_idx_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              err_o
);

  logic [ADDR_W-1:0] word_off;
  logic              req_err;
  logic              accept;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  logic              s1_valid;
  logic              s1_err;
  logic [ADDR_W-1:0] s1_pc;
  fetch_resp_t       s1;
  fetch_resp_t       last;

  always_comb begin
    word_off = (pc_i - BASE_ADDR) >> 2;
    req_err  = (pc_i[1:0] != 2'b00) || (word_off >= ADDR_W'(DEPTH_WORDS));
    accept   = rom_en_i && !stall_i && !flush_i && !rst;
    // Erroring fetches never touch storage; also keeps stage-1 data frozen on stall.
    rd_en    = accept && !req_err;
  end

  inst_rom_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (word_off[IDX_W-1:0]),
    .rd_data (rd_data),
    .wr_en   (load_en_i),
    .wr_idx  (load_idx_i),
    .wr_data (load_data_i)
  );

  // Stage 1: control fields beside the array's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_pc    <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (!stall_i) begin
      s1_valid <= accept;
      s1_err   <= req_err;
      s1_pc    <= pc_i;
    end
  end

  // The array register is not reset and holds stale data on errors, so the
  // data field is forced to zero unless stage 1 carries a good response.
  always_comb begin
    s1       = '0;
    s1.valid = s1_valid;
    s1.pc    = s1_pc;
    s1.err   = s1_err;
    s1.data  = (s1_valid && !s1_err) ? rd_data : '0;
  end

  generate
    if (LATENCY <= 1) begin : g_lat1
      always_comb last = s1;
    end else begin : g_chain
      fetch_resp_t chain_q [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < LATENCY - 1; i++) chain_q[i] <= '0;
        end else if (flush_i) begin
          for (int unsigned i = 0; i < LATENCY - 1; i++) chain_q[i].valid <= 1'b0;
        end else if (!stall_i) begin
          chain_q[0] <= s1;
          for (int unsigned i = 1; i < LATENCY - 1; i++) chain_q[i] <= chain_q[i-1];
        end
      end

      always_comb last = chain_q[LATENCY-2];
    end
  endgenerate

  always_comb begin
    inst_o       = last.data;
    inst_valid_o = last.valid;
    inst_pc_o    = last.pc;
    err_o        = last.err;
  end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench for inst_rom_responder: three instances (LATENCY 1, 2, 3) share
// all inputs; an age-based pending-fetch queue predicts their outputs.
module tb_inst_rom_responder;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_en = 1'b0;
  logic [31:0] pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_idx = '0;
  logic [31:0] load_data = '0;

  logic [31:0] inst   [3];
  logic        valid  [3];
  logic [31:0] pc_out [3];
  logic        err    [3];

  always #5 clk = ~clk;

  inst_rom_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .rom_en_i(rom_en), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .load_en_i(load_en), .load_idx_i(load_idx), .load_data_i(load_data),
    .inst_o(inst[0]), .inst_valid_o(valid[0]), .inst_pc_o(pc_out[0]), .err_o(err[0]));
  inst_rom_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .rom_en_i(rom_en), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .load_en_i(load_en), .load_idx_i(load_idx), .load_data_i(load_data),
    .inst_o(inst[1]), .inst_valid_o(valid[1]), .inst_pc_o(pc_out[1]), .err_o(err[1]));
  inst_rom_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .rom_en_i(rom_en), .pc_i(pc), .stall_i(stall), .flush_i(flush),
    .load_en_i(load_en), .load_idx_i(load_idx), .load_data_i(load_data),
    .inst_o(inst[2]), .inst_valid_o(valid[2]), .inst_pc_o(pc_out[2]), .err_o(err[2]));

  // Reference model: storage image plus the list of fetches in flight, each
  // tagged with the number of unstalled edges it has seen since acceptance.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
    int unsigned age;
  } ent_t;

  logic [31:0] mem [1024];
  ent_t        pend [$];
  logic        ev    [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] edata [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] epc   [3] = '{32'h0, 32'h0, 32'h0};
  logic        eerr  [3] = '{1'b0, 1'b0, 1'b0};

  int tests = 0;
  int fails = 0;

  task automatic idle();
    rom_en = 1'b0; stall = 1'b0; flush = 1'b0; load_en = 1'b0; rst = 1'b0;
  endtask

  // Update the model from the inputs currently driven, then advance one edge.
  task automatic step();
    logic [31:0] off;
    logic        e;
    ent_t        n;
    off = (pc - BASE) >> 2;
    e   = (pc[1:0] != 2'b00) || (off >= 32'd1024);
    n.pc = pc; n.err = e; n.age = 1;
    n.data = e ? 32'h0 : mem[off[9:0]];
    if (rst) begin
      pend.delete();
      for (int d = 0; d < 3; d++) begin
        ev[d] = 1'b0; edata[d] = '0; epc[d] = '0; eerr[d] = 1'b0;
      end
    end else if (flush) begin
      pend.delete();
      for (int d = 0; d < 3; d++) ev[d] = 1'b0;
    end else if (!stall) begin
      foreach (pend[k]) pend[k].age++;
      if (rom_en) pend.push_back(n);
      while (pend.size() > 0 && pend[0].age > 3) void'(pend.pop_front());
      for (int d = 0; d < 3; d++) begin
        ev[d] = 1'b0;
        foreach (pend[k])
          if (pend[k].age == d + 1) begin
            ev[d] = 1'b1; edata[d] = pend[k].data; epc[d] = pend[k].pc; eerr[d] = pend[k].err;
          end
      end
    end
    if (load_en) mem[load_idx] = load_data;
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 1024; i++) begin
      load_en = 1'b1; load_idx = 10'(i);
      load_data = (i < 4) ? 32'h1111_1111 * 32'(i + 1) : $urandom;
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; rom_en = 1'b1; pc = BASE;
    step(); step();
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (valid[d] !== 1'b0 || inst[d] !== 32'h0 || pc_out[d] !== 32'h0 || err[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset L%0d: valid=%b inst=%h pc=%h err=%b, expected all zero",
                 d + 1, valid[d], inst[d], pc_out[d], err[d]);
      end
    end
    idle();
  endtask

  task automatic test_stream();
    for (int c = 0; c < 9; c++) begin
      rom_en = (c < 4); pc = BASE + 32'(4 * c);
      step();
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (valid[d] !== ev[d] || (ev[d] && (inst[d] !== edata[d] || pc_out[d] !== epc[d] || err[d] !== eerr[d]))) begin
          fails++;
          $display("FAIL stream L%0d c%0d: got v=%b inst=%h pc=%h err=%b, expected v=%b inst=%h pc=%h err=%b",
                   d + 1, c, valid[d], inst[d], pc_out[d], err[d], ev[d], edata[d], epc[d], eerr[d]);
        end
      end
    end
    idle();
  endtask

  task automatic test_latency();
    int seen = 0;
    for (int c = 0; c < 6; c++) begin
      rom_en = (c == 0); pc = 32'hBFC0_0004;
      step();
      if (valid[2] === 1'b1) begin
        seen++;
        tests++;
        if (c != 2 || inst[2] !== 32'h2222_2222) begin
          fails++;
          $display("FAIL latency3 timing: valid in cycle N+%0d inst=%h, expected N+3 inst=22222222", c + 1, inst[2]);
        end
      end
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (valid[d] !== ev[d] || (ev[d] && (inst[d] !== edata[d] || pc_out[d] !== epc[d] || err[d] !== eerr[d]))) begin
          fails++;
          $display("FAIL latency L%0d c%0d: got v=%b inst=%h pc=%h err=%b, expected v=%b inst=%h pc=%h err=%b",
                   d + 1, c, valid[d], inst[d], pc_out[d], err[d], ev[d], edata[d], epc[d], eerr[d]);
        end
      end
    end
    tests++;
    if (seen != 1) begin
      fails++;
      $display("FAIL latency3 count: %0d valid cycles, expected 1", seen);
    end
    idle();
  endtask

  task automatic test_error();
    logic [31:0] pcs [2] = '{32'hBFC0_0002, 32'hBFC0_1000};
    int errs = 0;
    for (int c = 0; c < 6; c++) begin
      rom_en = (c < 2); pc = (c < 2) ? pcs[c] : BASE;
      step();
      if (valid[0] === 1'b1 && err[0] === 1'b1 && inst[0] === 32'h0) errs++;
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (valid[d] !== ev[d] || (ev[d] && (inst[d] !== edata[d] || pc_out[d] !== epc[d] || err[d] !== eerr[d]))) begin
          fails++;
          $display("FAIL error L%0d c%0d: got v=%b inst=%h pc=%h err=%b, expected v=%b inst=%h pc=%h err=%b",
                   d + 1, c, valid[d], inst[d], pc_out[d], err[d], ev[d], edata[d], epc[d], eerr[d]);
        end
      end
    end
    tests++;
    if (errs != 2) begin
      fails++;
      $display("FAIL error count L1: %0d erroring responses, expected 2", errs);
    end
    idle();
  endtask

  task automatic test_stall();
    for (int c = 0; c < 10; c++) begin
      rom_en = (c < 5); pc = BASE + 32'(4 * c);
      stall  = (c == 3 || c == 4);
      step();
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (valid[d] !== ev[d] || (ev[d] && (inst[d] !== edata[d] || pc_out[d] !== epc[d] || err[d] !== eerr[d]))) begin
          fails++;
          $display("FAIL stall L%0d c%0d: got v=%b inst=%h pc=%h err=%b, expected v=%b inst=%h pc=%h err=%b",
                   d + 1, c, valid[d], inst[d], pc_out[d], err[d], ev[d], edata[d], epc[d], eerr[d]);
        end
      end
    end
    idle();
  endtask

  task automatic test_flush();
    logic [31:0] pcs [4] = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_000C, 32'hBFC0_0008};
    for (int c = 0; c < 8; c++) begin
      rom_en = (c < 4); pc = (c < 4) ? pcs[c] : BASE;
      flush  = (c == 2);
      step();
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (valid[d] !== ev[d] || (ev[d] && (inst[d] !== edata[d] || pc_out[d] !== epc[d] || err[d] !== eerr[d]))) begin
          fails++;
          $display("FAIL flush L%0d c%0d: got v=%b inst=%h pc=%h err=%b, expected v=%b inst=%h pc=%h err=%b",
                   d + 1, c, valid[d], inst[d], pc_out[d], err[d], ev[d], edata[d], epc[d], eerr[d]);
        end
      end
    end
    idle();
  endtask

  task automatic test_rbw();
    for (int c = 0; c < 6; c++) begin
      rom_en = (c < 2); pc = 32'hBFC0_0004;
      load_en = (c == 0); load_idx = 10'd1; load_data = 32'hDEAD_BEEF;
      step();
      if (c == 0) begin
        tests++;
        if (inst[0] !== 32'h2222_2222) begin
          fails++;
          $display("FAIL rbw old word: inst=%h, expected 22222222", inst[0]);
        end
      end
      if (c == 1) begin
        tests++;
        if (inst[0] !== 32'hDEAD_BEEF) begin
          fails++;
          $display("FAIL rbw new word: inst=%h, expected deadbeef", inst[0]);
        end
      end
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (valid[d] !== ev[d] || (ev[d] && (inst[d] !== edata[d] || pc_out[d] !== epc[d] || err[d] !== eerr[d]))) begin
          fails++;
          $display("FAIL rbw L%0d c%0d: got v=%b inst=%h pc=%h err=%b, expected v=%b inst=%h pc=%h err=%b",
                   d + 1, c, valid[d], inst[d], pc_out[d], err[d], ev[d], edata[d], epc[d], eerr[d]);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 8; c++) begin
      rom_en = (c == 0 || c == 2); pc = (c == 0) ? 32'hBFC0_0008 : 32'hBFC0_000C;
      rst = (c == 2);
      step();
      if (c == 2) begin
        for (int d = 0; d < 3; d++) begin
          tests++;
          if (valid[d] !== 1'b0 || inst[d] !== 32'h0 || pc_out[d] !== 32'h0 || err[d] !== 1'b0) begin
            fails++;
            $display("FAIL midreset L%0d: valid=%b inst=%h pc=%h err=%b, expected all zero",
                     d + 1, valid[d], inst[d], pc_out[d], err[d]);
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (valid[d] !== ev[d] || (ev[d] && (inst[d] !== edata[d] || pc_out[d] !== epc[d] || err[d] !== eerr[d]))) begin
          fails++;
          $display("FAIL midreset L%0d c%0d: got v=%b inst=%h pc=%h err=%b, expected v=%b inst=%h pc=%h err=%b",
                   d + 1, c, valid[d], inst[d], pc_out[d], err[d], ev[d], edata[d], epc[d], eerr[d]);
        end
      end
    end
    idle();
  endtask

  task automatic test_random();
    int unsigned r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      pc = BASE + 32'(4 * $urandom_range(0, 15));
      else if (r < 7) pc = BASE + 32'(4 * $urandom_range(0, 1023));
      else if (r < 8) pc = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (r < 9) pc = BASE + 32'(4 * $urandom_range(1024, 5000));
      else            pc = BASE - 32'(4 * $urandom_range(1, 100));
      rom_en    = ($urandom_range(0, 9) < 7);
      stall     = ($urandom_range(0, 9) < 2);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      load_en   = ($urandom_range(0, 9) == 0);
      load_idx  = 10'($urandom_range(0, 15));
      load_data = $urandom;
      step();
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (valid[d] !== ev[d] || (ev[d] && (inst[d] !== edata[d] || pc_out[d] !== epc[d] || err[d] !== eerr[d]))) begin
          fails++;
          $display("FAIL random L%0d c%0d: got v=%b inst=%h pc=%h err=%b, expected v=%b inst=%h pc=%h err=%b",
                   d + 1, c, valid[d], inst[d], pc_out[d], err[d], ev[d], edata[d], epc[d], eerr[d]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    preload();
    test_stream();
    test_latency();
    test_error();
    test_stall();
    test_flush();
    test_rbw();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
